// File: rtl/button_conditioner_if.sv
// Board-side key/switch bundle for the multiplier front end.
// master: the board (drives raw keys/switches, sees the clean signals).
// slave:  the conditioner (reads raw keys/switches, drives the clean signals).
interface button_conditioner_if #(
  parameter int SW_WIDTH = 8
);
  logic                Run_n;
  logic                Reset_Load_Clear_n;
  logic [SW_WIDTH-1:0] SW_raw;
  logic                Run;
  logic                Reset_Load_Clear;
  logic [SW_WIDTH-1:0] SW;
  logic                SW_Frozen;

  modport master (
    output Run_n, Reset_Load_Clear_n, SW_raw,
    input  Run, Reset_Load_Clear, SW, SW_Frozen
  );

  modport slave (
    input  Run_n, Reset_Load_Clear_n, SW_raw,
    output Run, Reset_Load_Clear, SW, SW_Frozen
  );
endinterface

// File: rtl/button_conditioner.sv
// Input conditioner for the 8-bit add-shift multiplier.
// Synchronizes and debounces the active-low Run and Reset/Load/Clear keys,
// synchronizes the operand switches and freezes them while Run is held.
// Reset/Load/Clear has priority: while it is down, Run is forced low.
// Optional build macro RUN_PULSE_EN: Run becomes a one-cycle pulse on the
// press instead of a level that lasts for the whole key press.
// Every output is driven from registers only; no input reaches an output
// combinationally.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_WIDTH        = 8
) (
  input logic                 Clk,
  input logic                 Reset,
  button_conditioner_if.slave bus
);

  localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NUM_KEYS = 2;
  localparam int KEY_RUN  = 0;
  localparam int KEY_RLC  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_state;

  assign key_raw[KEY_RUN] = bus.Run_n;
  assign key_raw[KEY_RLC] = bus.Reset_Load_Clear_n;

  // Both keys share the same synchronizer + debouncer; the state is kept in
  // the key's raw (active-low) sense so reset means "released".
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic             meta_reg;
      logic             sync_reg;
      logic             state_reg;
      logic [CNT_W-1:0] cnt_reg;

      // Two-flop synchronizer resting at the released (high) level.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= key_raw[gi];
          sync_reg <= meta_reg;
        end
      end

      // Flip the state only after DEBOUNCE_CYCLES consecutive disagreeing
      // samples; any agreeing sample restarts the count.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          state_reg <= 1'b1;
          cnt_reg   <= '0;
        end else if (sync_reg == state_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_reg <= sync_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign key_state[gi] = state_reg;
    end
  endgenerate

  logic run_lvl;
  logic rlc_lvl;

  assign run_lvl = ~key_state[KEY_RUN];
  assign rlc_lvl = ~key_state[KEY_RLC];

  logic [SW_WIDTH-1:0] sw_meta_reg;
  logic [SW_WIDTH-1:0] sw_sync_reg;
  logic [SW_WIDTH-1:0] sw_out_reg;

  // Two-flop synchronizer for the operand switches.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= bus.SW_raw;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  // Operand tracks the switches except while Run is held down, so the
  // multiplier never sees it change mid-multiply.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sw_out_reg <= '0;
    end else if (!run_lvl) begin
      sw_out_reg <= sw_sync_reg;
    end
  end

`ifdef RUN_PULSE_EN
  logic run_lvl_d_reg;

  // Previous debounced Run level, used to find the press edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_lvl_d_reg <= 1'b0;
    end else begin
      run_lvl_d_reg <= run_lvl;
    end
  end

  // A press that happens (or is still held) while Reset/Load/Clear is down
  // never produces a pulse, even after Reset/Load/Clear is released.
  assign bus.Run = run_lvl & ~run_lvl_d_reg & ~rlc_lvl;
`else
  assign bus.Run = run_lvl & ~rlc_lvl;
`endif

  assign bus.Reset_Load_Clear = rlc_lvl;
  assign bus.SW               = sw_out_reg;
  assign bus.SW_Frozen        = run_lvl;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4.
// A history-based model predicts every output on every cycle; directed
// checks with literal values pin the model at the interesting edges.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int SWW  = 8;
  localparam int HMAX = 2048;

`ifdef RUN_PULSE_EN
  localparam logic RUN_HELD = 1'b0;
`else
  localparam logic RUN_HELD = 1'b1;
`endif

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  int total = 0;
  int bad   = 0;

  button_conditioner_if #(.SW_WIDTH(SWW)) bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .SW_WIDTH       (SWW)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial forever #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp, input bit verbose);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end else if (verbose) begin
      $display("ok   %s = %0h t=%0t", name, got, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw samples taken at each clock edge since reset; a key's synced value
  // seen at edge k is the raw value sampled at edge k-2.
  logic           run_h [HMAX];
  logic           rlc_h [HMAX];
  logic [SWW-1:0] sw_h  [HMAX];
  int             ecnt     = 0;
  int             flip_run = 0;
  int             flip_rlc = 0;
  logic           st_run   = 1'b1;
  logic           st_rlc   = 1'b1;
  logic           exp_run  = 1'b0;
  logic           exp_rlc  = 1'b0;
  logic           exp_frz  = 1'b0;
  logic [SWW-1:0] exp_sw   = '0;

  function automatic logic synced_key(input bit is_rlc, input int k);
    if (k - 2 < 1) return 1'b1;
    return is_rlc ? rlc_h[k-2] : run_h[k-2];
  endfunction

  // The state flips at edge k when the DEB synced samples ending at edge k
  // all disagree with it and all come after its previous flip.
  function automatic bit key_flips(input bit is_rlc, input logic st,
                                   input int last, input int k);
    if (k - last < DEB) return 1'b0;
    for (int j = k - DEB + 1; j <= k; j++)
      if (synced_key(is_rlc, j) == st) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    ecnt     = 0;
    flip_run = 0;
    flip_rlc = 0;
    st_run   = 1'b1;
    st_rlc   = 1'b1;
    exp_run  = 1'b0;
    exp_rlc  = 1'b0;
    exp_frz  = 1'b0;
    exp_sw   = '0;
  endtask

  task automatic model_edge();
    logic old_run_lvl;
    ecnt++;
    if (ecnt >= HMAX) begin
      $display("FAIL model history overflow at edge %0d", ecnt);
      $fatal(1);
    end
    run_h[ecnt] = bus.Run_n;
    rlc_h[ecnt] = bus.Reset_Load_Clear_n;
    sw_h[ecnt]  = bus.SW_raw;
    old_run_lvl = ~st_run;
    if (key_flips(1'b0, st_run, flip_run, ecnt)) begin
      st_run   = ~st_run;
      flip_run = ecnt;
    end
    if (key_flips(1'b1, st_rlc, flip_rlc, ecnt)) begin
      st_rlc   = ~st_rlc;
      flip_rlc = ecnt;
    end
    if (!old_run_lvl) exp_sw = (ecnt - 2 >= 1) ? sw_h[ecnt-2] : '0;
    exp_rlc = ~st_rlc;
    exp_frz = ~st_run;
`ifdef RUN_PULSE_EN
    exp_run = ~st_run & ~old_run_lvl & st_rlc;
`else
    exp_run = ~st_run & st_rlc;
`endif
  endtask

  initial begin
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) model_clear();
      else       model_edge();
    end
  end

  // Compare every output against the model on every falling edge.
  initial begin
    forever begin
      @(negedge Clk);
      check("m_Run",       {31'd0, bus.Run},              {31'd0, exp_run}, 1'b0);
      check("m_RLC",       {31'd0, bus.Reset_Load_Clear}, {31'd0, exp_rlc}, 1'b0);
      check("m_SW_Frozen", {31'd0, bus.SW_Frozen},        {31'd0, exp_frz}, 1'b0);
      check("m_SW",        {24'd0, bus.SW},               {24'd0, exp_sw},  1'b0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    bus.Run_n              = 1'b1;
    bus.Reset_Load_Clear_n = 1'b1;
    bus.SW_raw             = '0;
    cyc(3);
    check("rst_Run",       {31'd0, bus.Run},              32'd0, 1'b1);
    check("rst_RLC",       {31'd0, bus.Reset_Load_Clear}, 32'd0, 1'b1);
    check("rst_SW",        {24'd0, bus.SW},               32'd0, 1'b1);
    check("rst_SW_Frozen", {31'd0, bus.SW_Frozen},        32'd0, 1'b1);
    Reset = 1'b0;
    cyc(2);

    // Clean press and release.
    bus.Run_n = 1'b0;
    cyc(5);
    check("press_e5_Run", {31'd0, bus.Run}, 32'd0, 1'b1);
    cyc(1);
    check("press_e6_Run", {31'd0, bus.Run}, 32'd1, 1'b1);
    cyc(3);
    bus.Run_n = 1'b1;
    cyc(5);
    check("rel_e5_Run", {31'd0, bus.Run},       {31'd0, RUN_HELD}, 1'b1);
    check("rel_e5_Frz", {31'd0, bus.SW_Frozen}, 32'd1,             1'b1);
    cyc(1);
    check("rel_e6_Run", {31'd0, bus.Run},       32'd0, 1'b1);
    check("rel_e6_Frz", {31'd0, bus.SW_Frozen}, 32'd0, 1'b1);
    cyc(3);

    // Bouncing press: low 2, high 1, then steady low.
    bus.Run_n = 1'b0;
    cyc(2);
    bus.Run_n = 1'b1;
    cyc(1);
    bus.Run_n = 1'b0;
    cyc(5);
    check("bounce_e5_Run", {31'd0, bus.Run}, 32'd0, 1'b1);
    cyc(1);
    check("bounce_e6_Run", {31'd0, bus.Run}, 32'd1, 1'b1);
    bus.Run_n = 1'b1;
    cyc(8);

    // Switch tracking and freeze.
    bus.SW_raw = 8'h3C;
    cyc(2);
    check("sw_e2", {24'd0, bus.SW}, 32'h00, 1'b1);
    cyc(1);
    check("sw_e3", {24'd0, bus.SW}, 32'h3C, 1'b1);
    bus.Run_n = 1'b0;
    cyc(6);
    check("frz_Run", {31'd0, bus.Run},       32'd1, 1'b1);
    check("frz_Frz", {31'd0, bus.SW_Frozen}, 32'd1, 1'b1);
    bus.SW_raw = 8'hFF;
    cyc(4);
    check("frz_SW_hold", {24'd0, bus.SW}, 32'h3C, 1'b1);
    bus.Run_n = 1'b1;
    cyc(6);
    check("unfrz_e6_Frz", {31'd0, bus.SW_Frozen}, 32'd0,  1'b1);
    check("unfrz_e6_SW",  {24'd0, bus.SW},        32'h3C, 1'b1);
    cyc(1);
    check("unfrz_e7_SW",  {24'd0, bus.SW},        32'hFF, 1'b1);
    cyc(3);

    // Both keys down: Reset/Load/Clear wins.
    bus.Run_n              = 1'b0;
    bus.Reset_Load_Clear_n = 1'b0;
    cyc(5);
    check("both_e5_RLC", {31'd0, bus.Reset_Load_Clear}, 32'd0, 1'b1);
    cyc(1);
    check("both_e6_RLC", {31'd0, bus.Reset_Load_Clear}, 32'd1, 1'b1);
    check("both_e6_Run", {31'd0, bus.Run},              32'd0, 1'b1);
    check("both_e6_Frz", {31'd0, bus.SW_Frozen},        32'd1, 1'b1);
    cyc(2);
    bus.Reset_Load_Clear_n = 1'b1;
    cyc(5);
    check("rlcrel_e5_RLC", {31'd0, bus.Reset_Load_Clear}, 32'd1, 1'b1);
    check("rlcrel_e5_Run", {31'd0, bus.Run},              32'd0, 1'b1);
    cyc(1);
    check("rlcrel_e6_RLC", {31'd0, bus.Reset_Load_Clear}, 32'd0,             1'b1);
    check("rlcrel_e6_Run", {31'd0, bus.Run},              {31'd0, RUN_HELD}, 1'b1);
    cyc(2);
    check("rlcrel_e8_Run", {31'd0, bus.Run},              {31'd0, RUN_HELD}, 1'b1);
    bus.Run_n = 1'b1;
    cyc(8);

`ifdef RUN_PULSE_EN
    // Long hold produces exactly one pulse.
    bus.Run_n = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge Clk);
      if (bus.Run) n++;
    end
    check("pulse_count", n, 32'd1, 1'b1);
    bus.Run_n = 1'b1;
    cyc(8);
`else
    n = 0;
`endif

    // Asynchronous reset while Run is held and SW is frozen.
    bus.SW_raw = 8'h5A;
    bus.Run_n  = 1'b0;
    cyc(8);
    check("pre_rst_SW",  {24'd0, bus.SW},        32'h5A, 1'b1);
    check("pre_rst_Frz", {31'd0, bus.SW_Frozen}, 32'd1,  1'b1);
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("arst_Run", {31'd0, bus.Run},              32'd0, 1'b1);
    check("arst_RLC", {31'd0, bus.Reset_Load_Clear}, 32'd0, 1'b1);
    check("arst_SW",  {24'd0, bus.SW},               32'd0, 1'b1);
    check("arst_Frz", {31'd0, bus.SW_Frozen},        32'd0, 1'b1);
    @(negedge Clk);
    Reset = 1'b0;
    cyc(5);
    check("rearm_e5_Run", {31'd0, bus.Run},       32'd0, 1'b1);
    check("rearm_e5_Frz", {31'd0, bus.SW_Frozen}, 32'd0, 1'b1);
    cyc(1);
    check("rearm_e6_Run", {31'd0, bus.Run},       32'd1, 1'b1);
    check("rearm_e6_Frz", {31'd0, bus.SW_Frozen}, 32'd1, 1'b1);
    bus.Run_n = 1'b1;
    cyc(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
